context_sequencer: RTL and testbench
====================================

CONTEXT_SEQUENCER -- requirements
Module: context_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, context memory address width; SHALL match the control unit's context address width.
REQ-002 Parameter CYC_W, default 16, width of the run-cycle counter.
REQ-003 CLK_I  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST_N_I  in  1  reset, asynchronous assert, active-low.
REQ-005 START_I  in  1  one-cycle request; starts a load-and-run job; sampled only in IDLE.
REQ-006 LEN_I  in  ADDR_W+1  number of context words to load, sampled with START_I.
REQ-007 ENTRY_I  in  ADDR_W  start PC, sampled with START_I.
REQ-008 HALT_I  in  ADDR_W  halt PC, sampled with START_I.
REQ-009 ABORT_I  in  1  forces return to IDLE from any non-IDLE state.
REQ-010 WVALID_I  in  1  / WDATA_I  in  ADDR_W+2  / WREADY_O  out  1  context-word stream (valid/ready).
REQ-011 PC_I  in  ADDR_W  current PC fed back from the control unit.
REQ-012 CU_WR_EN_O  out  1, CU_ADDR_O  out  ADDR_W, CU_DATA_O  out  ADDR_W+2, CU_LOAD_EN_O  out  1, CU_EN_O  out  1  control-unit drive.
REQ-013 BUSY_O  out  1  high in any state other than IDLE and DONE.
REQ-014 DONE_O  out  1  high while in DONE.
REQ-015 CYCLES_O  out  CYC_W  count of RUN cycles in the last or current job.

Function
REQ-016 States SHALL be IDLE, LOAD, ENTRY, RUN, DONE; all outputs registered unless stated below.
REQ-017 IDLE: START_I=1 with LEN_I!=0 -> LOAD, latch LEN/ENTRY/HALT, clear word counter and CYCLES_O; START_I=1 with LEN_I=0 -> ENTRY (no load).
REQ-018 LOAD: WREADY_O=1; each cycle with WVALID_I&WREADY_O SHALL write WDATA_I to address = word counter (counter starts 0, +1 per transfer) via CU_WR_EN_O/CU_ADDR_O/CU_DATA_O, combinationally from the handshake.
REQ-019 LOAD: no transfer when WVALID_I=0; CU_WR_EN_O SHALL be 0 that cycle; counter holds.
REQ-020 LOAD -> ENTRY on the transfer that makes counter equal LEN; LEN = 2^ADDR_W SHALL load every address with no wrap or extra write.
REQ-021 ENTRY: exactly one cycle with CU_LOAD_EN_O=1, CU_EN_O=1, CU_ADDR_O=ENTRY, CU_WR_EN_O=0 -> RUN.
REQ-022 RUN: CU_EN_O=1, CU_LOAD_EN_O=0, CU_WR_EN_O=0; CYCLES_O +1 per cycle, saturating at all-ones.
REQ-023 RUN -> DONE when PC_I==HALT at a clock edge; that cycle SHALL still count and CU_EN_O SHALL drop in DONE.
REQ-024 RUN -> DONE also when CYCLES_O saturates (watchdog); CYCLES_O SHALL read all-ones.
REQ-025 DONE: CU_EN_O=0, DONE_O=1, CYCLES_O held; START_I behaves as in IDLE (REQ-017).
REQ-026 ABORT_I=1 in LOAD/ENTRY/RUN -> IDLE next edge, CU_* strobes 0 that edge on; ABORT_I SHALL take priority over every other transition, including a same-cycle halt match or final word.
REQ-027 START_I outside IDLE/DONE SHALL be ignored; WVALID_I outside LOAD SHALL be ignored (WREADY_O=0).
REQ-028 CU_ADDR_O SHALL equal the word counter in LOAD, ENTRY in ENTRY, 0 otherwise; CU_DATA_O = WDATA_I in LOAD, 0 otherwise.

Reset
REQ-029 RST_N_I=0 SHALL immediately force IDLE, CU_WR_EN_O=CU_LOAD_EN_O=CU_EN_O=0, WREADY_O=BUSY_O=DONE_O=0, CYCLES_O=0, counters 0, regardless of clock.
REQ-030 Reset mid-LOAD or mid-RUN SHALL discard the job; after release the block SHALL wait in IDLE for START_I.

Verification
REQ-031 ADDR_W=4: START LEN=3 ENTRY=0 HALT=2, words A,B,C with WVALID always 1 -> writes addr0=A,1=B,2=C on 3 consecutive cycles, one ENTRY cycle with CU_ADDR_O=0, RUN until PC_I=2, DONE_O=1.
REQ-032 Same job, WVALID gapped 1,0,0,1,1 -> exactly 3 writes, addresses 0,1,2, no write on gap cycles.
REQ-033 LEN=0, ENTRY=5, HALT=5 with PC_I=5 from first RUN cycle -> no writes, one ENTRY cycle, DONE after 1 RUN cycle, CYCLES_O=1.
REQ-034 CYC_W=4, HALT never reached -> DONE after 15 RUN cycles, CYCLES_O=15.
REQ-035 ABORT_I on the cycle of the last word handshake -> no ENTRY cycle, IDLE next, CU_LOAD_EN_O never 1.
REQ-036 RST_N_I low mid-RUN between edges -> CU_EN_O=0 and BUSY_O=0 without a clock edge; CYCLES_O=0.

Source files
------------

// File: rtl/context_sequencer.sv
// Context sequencer: streams context words into a control unit's memory, fires the
// entry load, then runs the unit until a halt PC match or a cycle-count watchdog.
module context_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CYC_W  = 16
) (
    input  logic              CLK_I,
    input  logic              RST_N_I,
    input  logic              START_I,
    input  logic [ADDR_W:0]   LEN_I,
    input  logic [ADDR_W-1:0] ENTRY_I,
    input  logic [ADDR_W-1:0] HALT_I,
    input  logic              ABORT_I,
    input  logic              WVALID_I,
    input  logic [ADDR_W+1:0] WDATA_I,
    output logic              WREADY_O,
    input  logic [ADDR_W-1:0] PC_I,
    output logic              CU_WR_EN_O,
    output logic [ADDR_W-1:0] CU_ADDR_O,
    output logic [ADDR_W+1:0] CU_DATA_O,
    output logic              CU_LOAD_EN_O,
    output logic              CU_EN_O,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic [CYC_W-1:0]  CYCLES_O
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ENTRY = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wcnt;
    logic [ADDR_W-1:0] r_entry;
    logic [ADDR_W-1:0] r_halt;
    logic [CYC_W-1:0]  r_cycles;

    logic              w_start;
    logic              w_xfer;
    logic              w_last_word;
    logic              w_halt_hit;
    logic              w_wdog;
    logic [CYC_W-1:0]  w_cyc_inc;

    assign w_start     = START_I && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_xfer      = (r_state == S_LOAD) && WVALID_I;
    // Counter is one bit wider than the address so a full 2^ADDR_W load terminates cleanly.
    assign w_last_word = w_xfer && ((r_wcnt + (ADDR_W+1)'(1)) == r_len);
    assign w_halt_hit  = (PC_I == r_halt);
    assign w_cyc_inc   = (&r_cycles) ? r_cycles : (r_cycles + CYC_W'(1));
    assign w_wdog      = &w_cyc_inc;

    // State register.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; abort outranks every other exit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START_I) begin
                    w_next = (LEN_I != {(ADDR_W+1){1'b0}}) ? S_LOAD : S_ENTRY;
                end else begin
                    w_next = r_state;
                end
            end
            S_LOAD: begin
                if (ABORT_I)          w_next = S_IDLE;
                else if (w_last_word) w_next = S_ENTRY;
                else                  w_next = S_LOAD;
            end
            S_ENTRY: begin
                if (ABORT_I) w_next = S_IDLE;
                else         w_next = S_RUN;
            end
            S_RUN: begin
                if (ABORT_I)                  w_next = S_IDLE;
                else if (w_halt_hit || w_wdog) w_next = S_DONE;
                else                          w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Job parameters, word counter and run-cycle counter.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_len    <= {(ADDR_W+1){1'b0}};
            r_wcnt   <= {(ADDR_W+1){1'b0}};
            r_entry  <= {ADDR_W{1'b0}};
            r_halt   <= {ADDR_W{1'b0}};
            r_cycles <= {CYC_W{1'b0}};
        end else if (w_start) begin
            r_len    <= LEN_I;
            r_wcnt   <= {(ADDR_W+1){1'b0}};
            r_entry  <= ENTRY_I;
            r_halt   <= HALT_I;
            r_cycles <= {CYC_W{1'b0}};
        end else if (w_xfer && !ABORT_I) begin
            r_wcnt   <= r_wcnt + (ADDR_W+1)'(1);
        end else if ((r_state == S_RUN) && !ABORT_I) begin
            r_cycles <= w_cyc_inc;
        end else begin
            r_wcnt   <= r_wcnt;
        end
    end

    // Output decode from the registered state; write strobe follows the live handshake.
    always_comb begin
        WREADY_O     = 1'b0;
        CU_WR_EN_O   = 1'b0;
        CU_ADDR_O    = {ADDR_W{1'b0}};
        CU_DATA_O    = {(ADDR_W+2){1'b0}};
        CU_LOAD_EN_O = 1'b0;
        CU_EN_O      = 1'b0;
        BUSY_O       = 1'b0;
        DONE_O       = 1'b0;
        CYCLES_O     = r_cycles;
        case (r_state)
            S_LOAD: begin
                WREADY_O   = 1'b1;
                CU_WR_EN_O = WVALID_I;
                CU_ADDR_O  = r_wcnt[ADDR_W-1:0];
                CU_DATA_O  = WDATA_I;
                BUSY_O     = 1'b1;
            end
            S_ENTRY: begin
                CU_LOAD_EN_O = 1'b1;
                CU_EN_O      = 1'b1;
                CU_ADDR_O    = r_entry;
                BUSY_O       = 1'b1;
            end
            S_RUN: begin
                CU_EN_O = 1'b1;
                BUSY_O  = 1'b1;
            end
            S_DONE: begin
                DONE_O = 1'b1;
            end
            default: begin
                DONE_O = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_context_sequencer.sv
// Bench for context_sequencer: each job is expanded cycle by cycle into expected outputs
// (load words, one entry cycle, run until halt/watchdog, done) and compared on every negedge.
module tb_context_sequencer;
    localparam int AW = 4;
    localparam int CW = 4;
    localparam int DW = AW + 2;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, wvalid;
    logic [AW:0]   len;
    logic [AW-1:0] entry, halt, pc;
    logic [DW-1:0] wdata;
    logic          wready, cu_wr, cu_ld, cu_en, busy, done;
    logic [AW-1:0] cu_addr;
    logic [DW-1:0] cu_data;
    logic [CW-1:0] cycles;

    int checks = 0;
    int errors = 0;

    logic          e_wready, e_wr, e_ld, e_en, e_busy, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cyc;
    bit            cyc_known = 1'b0;
    bit            chk_on = 1'b0;
    bit            m_done = 1'b0;
    logic [CW-1:0] m_cycles = '0;

    context_sequencer #(.ADDR_W(AW), .CYC_W(CW)) dut (
        .CLK_I(clk), .RST_N_I(rst_n), .START_I(start), .LEN_I(len), .ENTRY_I(entry),
        .HALT_I(halt), .ABORT_I(abort), .WVALID_I(wvalid), .WDATA_I(wdata),
        .WREADY_O(wready), .PC_I(pc), .CU_WR_EN_O(cu_wr), .CU_ADDR_O(cu_addr),
        .CU_DATA_O(cu_data), .CU_LOAD_EN_O(cu_ld), .CU_EN_O(cu_en), .BUSY_O(busy),
        .DONE_O(done), .CYCLES_O(cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic wr_rdy, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic ld, input logic en,
                           input logic bsy, input logic dn, input logic [CW-1:0] cy);
        e_wready = wr_rdy; e_wr = wr; e_addr = a; e_data = d; e_ld = ld;
        e_en = en; e_busy = bsy; e_done = dn; e_cyc = cy;
    endtask

    task automatic idle_exp();
        set_exp(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, m_done, m_cycles);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("wready", int'(wready), int'(e_wready));
            chk("cu_wr_en", int'(cu_wr), int'(e_wr));
            chk("cu_addr", int'(cu_addr), int'(e_addr));
            chk("cu_data", int'(cu_data), int'(e_data));
            chk("cu_load_en", int'(cu_ld), int'(e_ld));
            chk("cu_en", int'(cu_en), int'(e_en));
            chk("busy", int'(busy), int'(e_busy));
            chk("done", int'(done), int'(e_done));
            if (cyc_known) chk("cycles", int'(cycles), int'(e_cyc));
        end
    end

    // One job: abort_word = handshake number to abort on (0 none), abort_run = run cycle to abort on.
    task automatic run_job(input logic [AW:0] l, input logic [AW-1:0] en_pc, input logic [AW-1:0] h,
                           input logic [15:0] vpat, input int abort_word, input int abort_run);
        int k = 0;
        int p = 0;
        int r = 0;
        bit aborted = 1'b0;
        step();
        start = 1'b1; len = l; entry = en_pc; halt = h; wvalid = 1'b0; abort = 1'b0;
        idle_exp();
        step();
        start = 1'b0; len = ~l; entry = ~en_pc; halt = ~h;
        m_done = 1'b0; m_cycles = '0; cyc_known = 1'b1;
        if (l != '0) begin
            while ((int'(k) < int'(l)) && (p < 100)) begin
                if (p > 0) step();
                wvalid = vpat[p % 16];
                wdata  = DW'(p * 11 + 1);
                pc     = h;
                abort  = (abort_word != 0) && wvalid && (k + 1 == abort_word);
                set_exp(1'b1, wvalid, AW'(k), wdata, 1'b0, 1'b0, 1'b1, 1'b0, '0);
                if (wvalid) k++;
                p++;
                if (abort) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (aborted) begin
                step();
                abort = 1'b0; wvalid = 1'b0;
                idle_exp();
                step();
                idle_exp();
                return;
            end
            step();
        end
        wvalid = 1'b1; wdata = 6'h3F; pc = h;
        set_exp(1'b0, 1'b0, en_pc, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        while (r < 16) begin
            step();
            r++;
            wvalid = 1'b0;
            start  = 1'b1;
            pc     = en_pc + AW'(r - 1);
            set_exp(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, CW'(r - 1));
            if (abort_run == r) begin
                abort = 1'b1;
                step();
                abort = 1'b0; start = 1'b0;
                m_done = 1'b0; cyc_known = 1'b0;
                idle_exp();
                step();
                return;
            end
            if ((pc == h) || (r == (1 << CW) - 1)) break;
        end
        step();
        start = 1'b0;
        m_done = 1'b1; m_cycles = CW'(r);
        idle_exp();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wvalid = 1'b0;
        len = '0; entry = '0; halt = '0; pc = '0; wdata = '0;
        idle_exp();
        #3;
        chk("rst_wready", int'(wready), 0);
        chk("rst_cu_wr", int'(cu_wr), 0);
        chk("rst_cu_ld", int'(cu_ld), 0);
        chk("rst_cu_en", int'(cu_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cycles", int'(cycles), 0);
        step();
        step();
        rst_n = 1'b1; cyc_known = 1'b1; chk_on = 1'b1;
        step();

        run_job(5'd3, 4'd0, 4'd2, 16'hFFFF, 0, 0);
        chk("jobA_cycles", int'(cycles), 3);
        chk("jobA_done", int'(done), 1);
        run_job(5'd3, 4'd0, 4'd2, 16'h0019, 0, 0);
        chk("jobB_cycles", int'(cycles), 3);
        run_job(5'd0, 4'd5, 4'd5, 16'hFFFF, 0, 0);
        chk("jobC_cycles", int'(cycles), 1);
        run_job(5'd16, 4'd3, 4'd15, 16'h5555, 0, 0);
        chk("jobD_cycles", int'(cycles), 13);
        run_job(5'd1, 4'd0, 4'd15, 16'hFFFF, 0, 0);
        chk("wdog_cycles", int'(cycles), 15);
        chk("wdog_done", int'(done), 1);
        run_job(5'd2, 4'd0, 4'd1, 16'hFFFF, 2, 0);
        chk("abort_load_busy", int'(busy), 0);
        chk("abort_load_done", int'(done), 0);
        run_job(5'd0, 4'd2, 4'd2, 16'hFFFF, 0, 1);
        chk("abort_run_done", int'(done), 0);
        chk("abort_run_busy", int'(busy), 0);

        // Reset asserted between edges in the middle of a run.
        step();
        start = 1'b1; len = '0; entry = 4'd0; halt = 4'd9;
        idle_exp();
        step();
        start = 1'b0; m_done = 1'b0; m_cycles = '0; cyc_known = 1'b1;
        set_exp(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        step();
        pc = 4'd0;
        set_exp(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step();
        pc = 4'd1;
        set_exp(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        #2;
        rst_n = 1'b0;
        idle_exp();
        #1;
        chk("midrst_cu_en", int'(cu_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_cycles", int'(cycles), 0);
        step();
        rst_n = 1'b1; wvalid = 1'b1;
        step();
        step();
        wvalid = 1'b0;
        run_job(5'd1, 4'd7, 4'd8, 16'hFFFF, 0, 0);
        chk("post_rst_cycles", int'(cycles), 2);
        step();
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
